// File: rtl/jtdsp16_sio_rx.sv
// DSP16 serial-output receiver: rebuilds 16-bit words from OutCLK/data/address/OutLoad
// and steers them to left/right channel registers by address bit 0.
module jtdsp16_sio_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic        ock,
  input  logic        sio_do,
  input  logic        sadd,
  input  logic        old,
  output logic [15:0] left,
  output logic [15:0] right,
  output logic [7:0]  addr,
  output logic        l_stb,
  output logic        r_stb,
  output logic        pair_stb,
  output logic        err
);

  logic        last_ock_q, old_q;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [15:0] dsr_q, dsr_d;
  logic [7:0]  asr_q, asr_d;
  logic [15:0] left_q, left_d, right_q, right_d;
  logic [7:0]  addr_q, addr_d;
  logic        l_stb_q, l_stb_d, r_stb_q, r_stb_d;
  logic        pair_stb_q, pair_stb_d, err_q, err_d;
  logic        lf_q, lf_d, rf_q, rf_d;

  logic        ock_rise, capture, abort, lf_nxt, rf_nxt;
  logic [15:0] word;

  always_comb begin
    ock_rise = ock & ~last_ock_q;
    capture  = ock_rise & ~old;
    // A completing capture leaves bitcnt at 0, so it always wins over an abort
    abort    = old & ~old_q & (bitcnt_q != 4'd0) & ~capture;
    word     = {dsr_q[14:0], sio_do};

    bitcnt_d   = bitcnt_q;
    dsr_d      = dsr_q;
    asr_d      = asr_q;
    left_d     = left_q;
    right_d    = right_q;
    addr_d     = addr_q;
    l_stb_d    = 1'b0;
    r_stb_d    = 1'b0;
    pair_stb_d = 1'b0;
    err_d      = 1'b0;

    if (capture) begin
      dsr_d    = word;
      bitcnt_d = bitcnt_q + 4'd1;
      if (bitcnt_q < 4'd8) asr_d = {asr_q[6:0], sadd};
      if (bitcnt_q == 4'd15) begin
        addr_d = asr_q;
        if (asr_q[0]) begin
          right_d = word;
          r_stb_d = 1'b1;
        end else begin
          left_d  = word;
          l_stb_d = 1'b1;
        end
      end
    end else if (abort) begin
      bitcnt_d = 4'd0;
      dsr_d    = 16'd0;
      asr_d    = 8'd0;
      err_d    = 1'b1;
    end

    lf_nxt = lf_q | l_stb_q;
    rf_nxt = rf_q | r_stb_q;
    if (lf_nxt && rf_nxt) begin
      pair_stb_d = 1'b1;
      lf_d       = 1'b0;
      rf_d       = 1'b0;
    end else begin
      lf_d = lf_nxt;
      rf_d = rf_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_ock_q <= 1'b0;
      old_q      <= 1'b1;
      bitcnt_q   <= 4'd0;
      dsr_q      <= 16'd0;
      asr_q      <= 8'd0;
      left_q     <= 16'd0;
      right_q    <= 16'd0;
      addr_q     <= 8'd0;
      l_stb_q    <= 1'b0;
      r_stb_q    <= 1'b0;
      pair_stb_q <= 1'b0;
      err_q      <= 1'b0;
      lf_q       <= 1'b0;
      rf_q       <= 1'b0;
    end else begin
      last_ock_q <= ock;
      old_q      <= old;
      bitcnt_q   <= bitcnt_d;
      dsr_q      <= dsr_d;
      asr_q      <= asr_d;
      left_q     <= left_d;
      right_q    <= right_d;
      addr_q     <= addr_d;
      l_stb_q    <= l_stb_d;
      r_stb_q    <= r_stb_d;
      pair_stb_q <= pair_stb_d;
      err_q      <= err_d;
      lf_q       <= lf_d;
      rf_q       <= rf_d;
    end
  end

  assign left     = left_q;
  assign right    = right_q;
  assign addr     = addr_q;
  assign l_stb    = l_stb_q;
  assign r_stb    = r_stb_q;
  assign pair_stb = pair_stb_q;
  assign err      = err_q;

endmodule

// File: doc/jtdsp16_sio_rx.md
# jtdsp16_sio_rx

Serial-output receiver for the DSP16 core. Consumes the serial output port (OutCLK, data, address bit, OutLoad) produced by the DSP16 serial I/O block and rebuilds 16-bit parallel samples. It steers each word to a left or right channel register using the serial address sent alongside the data, and flags complete stereo pairs for the downstream mixer/DAC. It sits between the DSP16 core and the sound output path, in the same clock domain as the core.

## Interface
Parameters:
- none

Ports:
- clk      input   1   system clock, same clock as the DSP16 core
- rst      input   1   asynchronous reset, active high
- ock      input   1   serial output clock from DSP16; data is sampled on its rising edge
- sio_do   input   1   serial data, MSB first
- sadd     input   1   serial address bit, MSB first, valid during the first 8 data bits
- old      input   1   output load, active low; low while a word is being shifted
- left     output  16  last completed left-channel word
- right    output  16  last completed right-channel word
- addr     output  8   address of the last completed word
- l_stb    output  1   one-cycle pulse: `left` updated
- r_stb    output  1   one-cycle pulse: `right` updated
- pair_stb output  1   one-cycle pulse: both channels updated since the previous pair_stb
- err      output  1   one-cycle pulse: frame aborted before 16 bits

## Operation
- Edge detect: `last_ock` register; `ock_rise = ock & ~last_ock`, evaluated every clk with no enable. Holding `ock` high for several clocks counts as one edge.
- Bit capture happens only on cycles with `ock_rise && !old`. On those cycles:
  - `sio_do` shifts into `dsr[15:0]` (shift left, new bit at LSB).
  - While `bitcnt < 8`, `sadd` shifts into `asr[7:0]`.
  - `bitcnt` (4 bits, 0..15) increments.
- A rising edge with `old == 1` is ignored. This is the edge on which the transmitter drives `old` low.
- Word complete: on the capture where `bitcnt == 15`:
  - The full word is `{dsr[14:0], sio_do}`.
  - `addr` is loaded with the assembled address.
  - `bitcnt` wraps to 0.
- Steering: address bit 0 selects the channel; 0 loads `left` and pulses `l_stb`, 1 loads `right` and pulses `r_stb`.
- Back-to-back words: `old` may stay low across words. The counter simply wraps and the next capture is bit 15 of the next word. No idle gap is required.
- Pair tracking: sticky flags `lf` and `rf` are set by the respective strobe.
  - When both are set, or become set, `pair_stb` pulses on the next cycle and both flags clear.
  - A second write to the same channel before the pair completes overwrites the data; the flag simply stays set.
- Abort: `old` rising (registered `old` 0 to 1) while `bitcnt != 0`:
  - `err` pulses for one cycle and `bitcnt` clears to 0.
  - The partial `dsr` and `asr` contents are discarded.
  - `left`, `right` and `addr` are unchanged.
- Simultaneous events: abort detection only applies when no capture happens in the same cycle. A capture that completes a word takes priority, because after it `bitcnt == 0`.
- Reset:
  - `left`, `right`, `addr`, `dsr` = 0; `asr` = 0.
  - `bitcnt`, `last_ock`, `lf`, `rf` = 0.
  - All strobes = 0.
  - Asserting reset mid-word discards the word. After release, reception restarts at the next `old` falling sequence or the next capture edge.

## Timing
- Capture latency: the word-complete capture happens on the clk edge where `ock_rise` is detected for bit 0.
- `left`/`right`/`addr` and `l_stb`/`r_stb` are valid one clk after that capture edge (registered).
- `pair_stb` follows the completing `l_stb`/`r_stb` by one clk.
- The receiver samples on the first clk where `ock_rise` is seen. The transmitter shifts on that same edge or later, so the inputs sampled are the pre-shift values. No extra delay is permitted.
- Throughput: one word per 16 `ock` periods. `ock` is CKI/6 at ph1 rate; there is no clk-rate limit beyond `ock` staying high or low for at least 1 clk.

## Test plan
- Single left word: `old` low, address 0x00, data 0x8001 sent MSB first over 16 rising edges -> `left`=0x8001, `addr`=0x00, one `l_stb`, no `r_stb`/`pair_stb`.
- Stereo pair: address 0x00 data 0x1234, then address 0x01 data 0xABCD, with `old` held low across both -> `left`=0x1234, `right`=0xABCD, `pair_stb` one clk after `r_stb`.
- Ignored first edge: `old` falls exactly on an `ock` rise with `sio_do`=1 -> that edge is not counted, and the word aligns to the following 16 edges.
- Abort: raise `old` after 9 bits -> `err` pulses once, outputs unchanged; the next full word 0x5555 to the right channel is received correctly.
- Stretched clock: `ock` held high 5 clks per edge, word 0xFFFF -> exactly 16 captures, `right` or `left`=0xFFFF, one strobe.
- Reset mid-word: assert `rst` after 7 bits -> all outputs 0. A following complete word 0x0F0F decodes correctly.
